// File: rtl/panel_input_port.sv
// -----------------------------------------------------------------------------
// panel_input_port
//   Read side of the board front panel. Synchronizes and debounces six
//   active-low pushbuttons and eight DIP switches, detects debounced button
//   presses, keeps sticky per-button press flags and exposes flags, button
//   levels and DIP levels as read-only registers on the CPU data bus.
//
// Ports
//   CLK_12MHz  in   system clock
//   RST_N      in   asynchronous active-low reset
//   Switch     in   [5:0] raw pushbuttons, 0 = pressed, asynchronous
//   DPSwitch   in   [7:0] raw DIP switches, 1 = on, asynchronous
//   rd_en      in   one-cycle read strobe
//   rd_addr    in   [7:0] read address, sampled with rd_en
//   rd_data    out  [7:0] registered read data
//   rd_valid   out  one-cycle pulse, rd_data valid
//   rd_hit     out  address decoded by this block (qualifies rd_valid)
//   btn_level  out  [5:0] debounced button state, 1 = pressed
//   btn_press  out  [5:0] one-cycle pulse per debounced press
//   irq        out  OR of all sticky press flags (combinational)
// -----------------------------------------------------------------------------
module panel_input_port #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned CNT_W           = 17,
  parameter logic [7:0]  FLAG_ADDR       = 8'hF6,
  parameter logic [7:0]  DIP_ADDR        = 8'hF7,
  parameter logic [7:0]  LEVEL_ADDR      = 8'hF8
) (
  input  logic       CLK_12MHz,
  input  logic       RST_N,
  input  logic [5:0] Switch,
  input  logic [7:0] DPSwitch,
  input  logic       rd_en,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       rd_hit,
  output logic [5:0] btn_level,
  output logic [5:0] btn_press,
  output logic       irq
);

  localparam int unsigned N_BTN  = 6;
  localparam int unsigned N_DIP  = 8;
  localparam int unsigned N_IN   = N_BTN + N_DIP;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned PAD_W  = DATA_W - N_BTN;

  // Terminal count: the sample that reaches it is the DEBOUNCE_CYCLES-th
  // consecutive differing sample, so the stable level flips on it.
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Two-flop synchronizers; reset loads the "released" pin levels.
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0] btn_meta;
  logic [N_BTN-1:0] btn_sync;
  logic [N_DIP-1:0] dip_meta;
  logic [N_DIP-1:0] dip_sync;

  always_ff @(posedge CLK_12MHz or negedge RST_N) begin
    if (!RST_N) begin
      btn_meta <= '1;
      btn_sync <= '1;
      dip_meta <= '0;
      dip_sync <= '0;
    end else begin
      btn_meta <= Switch;
      btn_sync <= btn_meta;
      dip_meta <= DPSwitch;
      dip_sync <= dip_meta;
    end
  end

  // Internal polarity: buttons inverted so 1 = pressed for every input.
  logic [N_IN-1:0] sync_vec;
  assign sync_vec = {dip_sync, ~btn_sync};

  // ---------------------------------------------------------------------------
  // Per-input debounce: counter runs only while the synchronized level
  // differs from the stable level; any agreement restarts from zero.
  // ---------------------------------------------------------------------------
  logic [N_IN-1:0] stable_q;
  logic [N_IN-1:0] stable_d;

  for (genvar i = 0; i < N_IN; i++) begin : g_db
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             bit_d;

    // Next count and next stable bit for this input.
    always_comb begin
      cnt_d = '0;
      bit_d = stable_q[i];
      if (sync_vec[i] != stable_q[i]) begin
        if (cnt_q == CNT_TERM) begin
          bit_d = sync_vec[i];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge CLK_12MHz or negedge RST_N) begin
      if (!RST_N) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign stable_d[i] = bit_d;
  end

  // Debounced state register for all fourteen inputs.
  always_ff @(posedge CLK_12MHz or negedge RST_N) begin
    if (!RST_N) begin
      stable_q <= '0;
    end else begin
      stable_q <= stable_d;
    end
  end

  logic [N_DIP-1:0] dip_level;
  assign btn_level = stable_q[N_BTN-1:0];
  assign dip_level = stable_q[N_IN-1:N_BTN];

  // ---------------------------------------------------------------------------
  // Press detection: rising edge of the debounced level, one cycle later.
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0] btn_prev;

  always_ff @(posedge CLK_12MHz or negedge RST_N) begin
    if (!RST_N) begin
      btn_prev  <= '0;
      btn_press <= '0;
    end else begin
      btn_prev  <= btn_level;
      btn_press <= btn_level & ~btn_prev;
    end
  end

  // ---------------------------------------------------------------------------
  // Read decode for the current cycle's request.
  // ---------------------------------------------------------------------------
  logic              rd_hit_c;
  logic [DATA_W-1:0] rd_mux_c;
  logic              flag_clr_c;
  logic [N_BTN-1:0]  sticky_q;

  always_comb begin
    rd_hit_c   = 1'b0;
    rd_mux_c   = '0;
    flag_clr_c = 1'b0;
    if (rd_en) begin
      case (rd_addr)
        FLAG_ADDR: begin
          rd_hit_c   = 1'b1;
          rd_mux_c   = {PAD_W'(0), sticky_q};
          flag_clr_c = 1'b1;
        end
        DIP_ADDR: begin
          rd_hit_c = 1'b1;
          rd_mux_c = dip_level;
        end
        LEVEL_ADDR: begin
          rd_hit_c = 1'b1;
          rd_mux_c = {PAD_W'(0), btn_level};
        end
        default: begin
          rd_hit_c = 1'b0;
          rd_mux_c = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky flags: a press in the same cycle as a flag read survives the clear.
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0] sticky_d;
  assign sticky_d = (flag_clr_c ? '0 : sticky_q) | btn_press;

  always_ff @(posedge CLK_12MHz or negedge RST_N) begin
    if (!RST_N) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign irq = |sticky_q;

  // ---------------------------------------------------------------------------
  // Read response registers; rd_data holds between reads.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_12MHz or negedge RST_N) begin
    if (!RST_N) begin
      rd_valid <= 1'b0;
      rd_hit   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      rd_hit   <= rd_hit_c;
      if (rd_en) begin
        rd_data <= rd_mux_c;
      end
    end
  end

endmodule

// File: tb/tb_panel_input_port.sv
// -----------------------------------------------------------------------------
// tb_panel_input_port
//   Self-checking bench for panel_input_port with DEBOUNCE_CYCLES=4, CNT_W=3.
//   Directed sequences and a read-vector table check fixed expectations; a
//   behavioural model (sample-history queue plus run-length counts) checks
//   every output on every falling edge, including a randomized phase.
// -----------------------------------------------------------------------------
module tb_panel_input_port;

  localparam int unsigned DEB   = 4;
  localparam int unsigned CW    = 3;
  localparam logic [7:0]  A_FLG = 8'hF6;
  localparam logic [7:0]  A_DIP = 8'hF7;
  localparam logic [7:0]  A_LVL = 8'hF8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Switch;
  logic [7:0] DPSwitch;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_hit;
  logic [5:0] btn_level;
  logic [5:0] btn_press;
  logic       irq;

  panel_input_port #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CW),
    .FLAG_ADDR      (A_FLG),
    .DIP_ADDR       (A_DIP),
    .LEVEL_ADDR     (A_LVL)
  ) dut (
    .CLK_12MHz(clk),
    .RST_N    (rst_n),
    .Switch   (Switch),
    .DPSwitch (DPSwitch),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_hit   (rd_hit),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [7:0] a, output logic v, output logic h, output logic [7:0] d);
    rd_en   = 1'b1;
    rd_addr = a;
    step(1);
    rd_en = 1'b0;
    v = rd_valid;
    h = rd_hit;
    d = rd_data;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Each input's debounced level flips once the sample seen
  // two edges after the pin has disagreed with it DEB times in a row.
  // ---------------------------------------------------------------------------
  logic [13:0] m_hist[$];
  int unsigned m_run[14];
  logic [13:0] m_lvl;
  logic [13:0] m_lvl_next;
  logic [5:0]  m_lvl_prev;
  logic [5:0]  m_press;
  logic [5:0]  m_flags;
  logic        m_valid;
  logic        m_hit;
  logic [7:0]  m_data;
  logic [13:0] m_seen;
  logic        m_clr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hist = '{14'h0, 14'h0};
      foreach (m_run[i]) m_run[i] = 0;
      m_lvl      = '0;
      m_lvl_prev = '0;
      m_press    = '0;
      m_flags    = '0;
      m_valid    = 1'b0;
      m_hit      = 1'b0;
      m_data     = '0;
    end else begin
      m_seen = m_hist.pop_front();
      m_hist.push_back({DPSwitch, ~Switch});
      m_lvl_next = m_lvl;
      for (int i = 0; i < 14; i++) begin
        if (m_seen[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_lvl_next[i] = m_seen[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_clr   = 1'b0;
      m_valid = rd_en;
      m_hit   = 1'b0;
      if (rd_en) begin
        m_data = 8'h00;
        if (rd_addr == A_FLG) begin
          m_hit = 1'b1; m_data = {2'b00, m_flags}; m_clr = 1'b1;
        end else if (rd_addr == A_DIP) begin
          m_hit = 1'b1; m_data = m_lvl[13:6];
        end else if (rd_addr == A_LVL) begin
          m_hit = 1'b1; m_data = {2'b00, m_lvl[5:0]};
        end
      end
      m_flags    = (m_clr ? 6'h00 : m_flags) | m_press;
      m_press    = m_lvl[5:0] & ~m_lvl_prev;
      m_lvl_prev = m_lvl[5:0];
      m_lvl      = m_lvl_next;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model btn_level", 32'(btn_level), 32'(m_lvl[5:0]));
      check("model btn_press", 32'(btn_press), 32'(m_press));
      check("model irq",       32'(irq),       32'(|m_flags));
      check("model rd_valid",  32'(rd_valid),  32'(m_valid));
      check("model rd_hit",    32'(rd_hit),    32'(m_hit));
      check("model rd_data",   32'(rd_data),   32'(m_data));
    end
  end

  // ---------------------------------------------------------------------------
  // Read-vector table: DIP setting to hold, address to read, expected response.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] dip;
    logic [7:0] addr;
    logic       hit;
    logic [7:0] data;
  } rd_vec_t;

  rd_vec_t     vecs[8];
  logic        v;
  logic        h;
  logic [7:0]  d;
  int          first_k;
  int          pulses;
  int          glitch;
  logic [5:0]  sw;
  logic [7:0]  dp;
  int unsigned r;

  initial begin
    vecs[0] = '{8'h00, 8'hF6, 1'b1, 8'h00};
    vecs[1] = '{8'h00, 8'hF7, 1'b1, 8'h00};
    vecs[2] = '{8'h00, 8'hF8, 1'b1, 8'h00};
    vecs[3] = '{8'hA5, 8'hF7, 1'b1, 8'hA5};
    vecs[4] = '{8'hA5, 8'h10, 1'b0, 8'h00};
    vecs[5] = '{8'h3C, 8'hF7, 1'b1, 8'h3C};
    vecs[6] = '{8'h3C, 8'hFF, 1'b0, 8'h00};
    vecs[7] = '{8'h00, 8'hF7, 1'b1, 8'h00};

    rst_n = 1'b0; Switch = 6'h3F; DPSwitch = 8'h00; rd_en = 1'b0; rd_addr = 8'h00;
    glitch = -1;
    step(3);
    chk_on = 1'b1;
    rst_n  = 1'b1;

    // Idle after reset, then the register table (includes DIP A5 and a miss).
    step(20);
    check("idle btn_level", 32'(btn_level), 0);
    check("idle btn_press", 32'(btn_press), 0);
    check("idle irq",       32'(irq),       0);
    check("idle rd_valid",  32'(rd_valid),  0);
    check("idle rd_hit",    32'(rd_hit),    0);
    check("idle rd_data",   32'(rd_data),   0);
    for (int i = 0; i < 8; i++) begin
      DPSwitch = vecs[i].dip;
      step(8);
      do_read(vecs[i].addr, v, h, d);
      check($sformatf("vec%0d rd_valid", i), 32'(v), 1);
      check($sformatf("vec%0d rd_hit", i),   32'(h), 32'(vecs[i].hit));
      check($sformatf("vec%0d rd_data", i),  32'(d), 32'(vecs[i].data));
    end

    // Clean press on button 2: level after 6 edges, pulse one cycle later.
    Switch[2] = 1'b0;
    step(5);
    check("b2 level early", 32'(btn_level[2]), 0);
    step(1);
    check("b2 level at 6", 32'(btn_level[2]), 1);
    check("b2 press before", 32'(btn_press), 0);
    step(1);
    check("b2 press pulse", 32'(btn_press), 32'(6'h04));
    step(1);
    check("b2 press ends", 32'(btn_press), 0);
    check("b2 irq", 32'(irq), 1);
    do_read(A_FLG, v, h, d);
    check("b2 flag read", 32'(d), 32'(8'h04));
    check("b2 irq after clear", 32'(irq), 0);
    do_read(A_FLG, v, h, d);
    check("b2 flag reread", 32'(d), 32'(8'h00));
    Switch[2] = 1'b1;
    step(10);

    // Bouncing button 0: no pulse while bouncing, exactly one once held.
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      Switch[0] = k[1];
      step(1);
      if (btn_press[0]) pulses++;
    end
    check("b0 bounce pulses", 32'(pulses), 0);
    Switch[0] = 1'b0;
    first_k = -1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (btn_press[0]) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
    end
    check("b0 held pulses", 32'(pulses), 1);
    check("b0 pulse timing", 32'(first_k), 7);
    Switch[0] = 1'b1;
    step(10);
    do_read(A_FLG, v, h, d);
    check("b0 flag read", 32'(d), 32'(8'h01));

    // Button 5 pulse coincides with a flag read while flag 1 is set.
    Switch[1] = 1'b0;
    step(10);
    check("b1 irq", 32'(irq), 1);
    Switch[1] = 1'b1;
    Switch[5] = 1'b0;
    step(7);
    check("b5 pulse now", 32'(btn_press), 32'(6'h20));
    do_read(A_FLG, v, h, d);
    check("setwins rd_valid", 32'(v), 1);
    check("setwins rd_data", 32'(d), 32'(8'h02));
    check("setwins irq", 32'(irq), 1);
    do_read(A_FLG, v, h, d);
    check("setwins reread", 32'(d), 32'(8'h20));
    Switch[5] = 1'b1;
    step(10);

    // Reset mid-count on button 3, with a read issued during reset.
    Switch[3] = 1'b0;
    step(4);
    rst_n = 1'b0;
    #1;
    check("rst btn_level", 32'(btn_level), 0);
    check("rst btn_press", 32'(btn_press), 0);
    check("rst irq",       32'(irq),       0);
    check("rst rd_data",   32'(rd_data),   0);
    rd_en = 1'b1; rd_addr = A_DIP;
    step(1);
    check("rst no rd_valid", 32'(rd_valid), 0);
    check("rst no rd_hit",   32'(rd_hit),   0);
    rd_en = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(5);
    check("b3 fresh early", 32'(btn_level[3]), 0);
    step(1);
    check("b3 fresh at 6", 32'(btn_level[3]), 1);
    Switch[3] = 1'b1;
    step(10);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      sw = Switch;
      dp = DPSwitch;
      if (glitch >= 0) begin
        sw[glitch] = ~sw[glitch];
        glitch = -1;
      end else begin
        r = $urandom_range(0, 99);
        if (r < 3) begin
          sw[$urandom_range(0, 5)] ^= 1'b1;
        end else if (r < 5) begin
          dp[$urandom_range(0, 7)] ^= 1'b1;
        end else if (r < 8) begin
          glitch = int'($urandom_range(0, 5));
          sw[glitch] = ~sw[glitch];
        end
      end
      Switch   = sw;
      DPSwitch = dp;
      rd_en    = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0:       rd_addr = A_FLG;
        1:       rd_addr = A_DIP;
        2:       rd_addr = A_LVL;
        default: rd_addr = 8'($urandom_range(0, 255));
      endcase
      step(1);
    end
    rd_en = 1'b0;
    step(2);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/panel_input_port.md
Name: panel_input_port

Overview:
- Read side of the board front panel: debounces the six active-low pushbuttons and the eight DIP switches.
- Detects button presses and keeps sticky per-button press flags.
- Exposes flags, button levels and DIP levels as memory-mapped read-only registers on the CPU data bus.
- The CPU polls this block instead of sampling raw switch pins.

Parameters:
- DEBOUNCE_CYCLES, 120000: consecutive stable clock cycles before a debounced level changes (10 ms at 12 MHz). Legal range 2..2^CNT_W.
- CNT_W, 17: width of each debounce counter.
- FLAG_ADDR, 8'hF6: address of the sticky press flags register; reading it clears the flags.
- DIP_ADDR, 8'hF7: address of the debounced DIP switch levels.
- LEVEL_ADDR, 8'hF8: address of the debounced button levels.

Ports:
- CLK_12MHz  input  1  system clock
- RST_N  input  1  asynchronous active-low reset
- Switch  input  6  raw pushbuttons; 0 = pressed; asynchronous to the clock
- DPSwitch  input  8  raw DIP switches; 1 = on; asynchronous to the clock
- rd_en  input  1  read strobe from the CPU, one cycle
- rd_addr  input  8  read address, sampled when rd_en=1
- rd_data  output  8  read data, registered
- rd_valid  output  1  one-cycle pulse; rd_data is valid in that cycle
- rd_hit  output  1  qualifies rd_valid: 1 = address decoded by this block
- btn_level  output  6  debounced button state; 1 = pressed
- btn_press  output  6  one-cycle pulse per button on each debounced press
- irq  output  1  OR of all sticky flags

Behaviour:
- Reset (async assert, synchronous release): all outputs 0.
  - Synchronizers load "released" (Switch 1s, DPSwitch 0s); debounced button state 0, DIP state 0.
  - All counters 0, all sticky flags 0.
- Synchronizer: each of the 14 inputs passes through 2 flops. Buttons are inverted after synchronization, so 1 = pressed internally.
- Debounce, per input, with its own CNT_W counter:
  - sync == stable: counter cleared.
  - sync != stable and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sync != stable and counter == DEBOUNCE_CYCLES-1: stable takes sync; counter cleared.
  - Any bounce back to the stable value before the terminal count clears the counter; there is no partial credit.
- Latency: a clean edge on a pin reaches btn_level/DIP state 2 + DEBOUNCE_CYCLES cycles after the first sampling edge.
- btn_press[i]:
  - Pulses for exactly 1 cycle, in the cycle after btn_level[i] goes 0->1.
  - Nothing on release. One pulse per debounced press, however long it is held.
- sticky[i]:
  - Set by btn_press[i].
  - Cleared by an accepted read of FLAG_ADDR.
  - If set and clear occur in the same cycle, set wins: the flag stays 1 and the read returns the pre-set value.
- Read handshake:
  - rd_en=1 in cycle N -> rd_valid=1 in cycle N+1, with rd_data/rd_hit registered from the cycle-N values.
  - FLAG_ADDR: {2'b00, sticky}; all flags cleared at the cycle-N edge, subject to the set-wins rule.
  - DIP_ADDR: debounced DIP state.
  - LEVEL_ADDR: {2'b00, btn_level}.
  - Any other address: rd_hit=0, rd_data=0.
  - rd_en=0: rd_valid=0, rd_hit=0, rd_data holds its last value.
  - Back-to-back reads every cycle are supported.
- irq: combinational OR of the registered sticky flags; no extra latency.
- Reset mid-debounce discards any partial count. Reset coincident with rd_en produces no rd_valid.

Test Plan:
Bench runs with DEBOUNCE_CYCLES=4, CNT_W=3.
1. Reset then idle 20 cycles, Switch=6'h3F, DPSwitch=8'h00 -> all outputs 0; read F6/F7/F8 -> rd_valid=1, rd_hit=1, rd_data=8'h00 each.
2. Switch[2] driven low cleanly ->
   - btn_level[2] rises exactly 6 cycles later, btn_press[2] pulses once in the following cycle, irq=1.
   - Read F6 -> 8'h04; read F6 again -> 8'h00 and irq=0.
3. Switch[0] bounces low/high every 2 cycles for 20 cycles, then held low -> no btn_press[0] during the bounce; a single pulse after 4 stable cycles plus sync delay.
4. Button 5 press pulse coincident with the rd_en of an F6 read while flag 1 is set -> rd_data=8'h02 and flag 1 cleared; flag 5 remains set; next F6 read -> 8'h20.
5. DPSwitch=8'hA5 held -> read F7 -> 8'hA5. Read address 8'h10 -> rd_valid=1, rd_hit=0, rd_data=8'h00.
6. RST_N asserted mid-count (2 stable cycles after a Switch[3] edge), then released with Switch[3] still low -> outputs 0 during reset; after release btn_level[3] rises only after a full fresh debounce (6 cycles).
